cobra_corpo: RTL



---
 rtl/cobra_pkg.sv | 24 ++
 rtl/cobra_seg_ram.sv | 29 ++
 rtl/cobra_corpo.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/cobra_pkg.sv
// Shared direction codes, grid defaults and FSM states for the snake body engine.
// Latency/backpressure: n/a (definitions only).
package cobra_pkg;

   localparam int GRID_W_DEF   = 32;
   localparam int GRID_H_DEF   = 24;
   localparam int MAX_LEN_DEF  = 64;
   localparam int INIT_LEN_DEF = 3;

   typedef logic [1:0] dir_t;

   localparam dir_t DIR_UP    = 2'b00;
   localparam dir_t DIR_DOWN  = 2'b01;
   localparam dir_t DIR_LEFT  = 2'b10;
   localparam dir_t DIR_RIGHT = 2'b11;

   typedef enum logic [2:0] {INIT, IDLE, CHECK, COMMIT, DEAD} cobra_state_t;

   // Opposite directions differ only in the LSB: up<->down, left<->right.
   function automatic dir_t rev_dir(input dir_t d);
      return {d[1], ~d[0]};
   endfunction

endpackage

// File: rtl/cobra_seg_ram.sv
// Segment ring buffer: one R/W port for the FSM, one read-only port for the renderer.
// Latency: reads registered, 1 cycle, read-before-write. Backpressure: none.
module cobra_seg_ram #(
   parameter int DEPTH = 64,
   parameter int XW    = 5,
   parameter int YW    = 5
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [XW-1:0]            wx,
   input  logic [YW-1:0]            wy,
   output logic [XW-1:0]            ax,
   output logic [YW-1:0]            ay,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [XW-1:0]            rx,
   output logic [YW-1:0]            ry
);

   logic [XW+YW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[addr] <= {wx, wy};
      {ax, ay} <= mem[addr];
      {rx, ry} <= mem[raddr];
   end

endmodule

// File: rtl/cobra_corpo.sv
// Snake body engine: on tick steps the head, checks wall/self collisions, stores the body in a ring buffer.
// Latency: tick->moved = 3 + segments compared; renderer read 1 cycle. Ticks while busy or dead are dropped.
// Build option COBRA_WRAP_EN wraps grid edges so only self-collision ends the game.
module cobra_corpo
   import cobra_pkg::*;
#(
   parameter int GRID_W   = GRID_W_DEF,
   parameter int GRID_H   = GRID_H_DEF,
   parameter int MAX_LEN  = MAX_LEN_DEF,
   parameter int INIT_LEN = INIT_LEN_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       tick,
   input  logic [1:0]                 cobra_dir,
   input  logic                       grow,
   input  logic [$clog2(MAX_LEN)-1:0] rd_idx,
   output logic [$clog2(GRID_W)-1:0]  rd_x,
   output logic [$clog2(GRID_H)-1:0]  rd_y,
   output logic                       rd_valid,
   output logic [$clog2(GRID_W)-1:0]  head_x,
   output logic [$clog2(GRID_H)-1:0]  head_y,
   output logic [$clog2(MAX_LEN):0]   length,
   output logic                       busy,
   output logic                       moved,
   output logic                       game_over
);

   localparam int XW = $clog2(GRID_W);
   localparam int YW = $clog2(GRID_H);
   localparam int AW = $clog2(MAX_LEN);
   localparam int LW = AW + 1;

   localparam logic [XW-1:0] X_ONE = XW'(1);
   localparam logic [YW-1:0] Y_ONE = YW'(1);
   localparam logic [AW-1:0] A_ONE = AW'(1);
   localparam logic [LW-1:0] L_ONE = LW'(1);
   localparam logic [LW-1:0] L_TWO = LW'(2);
   localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
   localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);
   localparam logic [LW-1:0] L_MAX = LW'(MAX_LEN);

`ifdef COBRA_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   cobra_state_t  state, state_nxt;
   dir_t          cur_dir, eff_dir;
   logic [AW-1:0] head_ptr, init_cnt, ram_addr;
   logic [LW-1:0] chk_i, chk_last;
   logic          cmp_vld, chk_issue, chk_hit, grow_pend, step_oob, ram_we;
   logic [XW-1:0] new_x, step_x, ram_wx, ram_ax;
   logic [YW-1:0] new_y, step_y, ram_wy, ram_ay;

   // Candidate head for the direction requested this cycle; x wraps for free since GRID_W is a power of 2.
   always_comb begin
      eff_dir  = (cobra_dir == rev_dir(cur_dir)) ? cur_dir : cobra_dir;
      step_x   = head_x;
      step_y   = head_y;
      step_oob = 1'b0;
      case (eff_dir)
         DIR_UP: begin
            step_oob = (head_y == '0);
            step_y   = step_oob ? Y_MAX : head_y - Y_ONE;
         end
         DIR_DOWN: begin
            step_oob = (head_y == Y_MAX);
            step_y   = step_oob ? '0 : head_y + Y_ONE;
         end
         DIR_LEFT: begin
            step_oob = (head_x == '0);
            step_x   = head_x - X_ONE;
         end
         default: begin
            step_oob = (head_x == X_MAX);
            step_x   = head_x + X_ONE;
         end
      endcase
      step_oob = step_oob & ~WRAP;
   end

   // The tail cell is only a hazard when it will not be vacated, i.e. when growing.
   assign chk_last = grow_pend ? length - L_ONE : length - L_TWO;
   assign chk_hit  = cmp_vld && (ram_ax == new_x) && (ram_ay == new_y);
   assign busy     = (state == INIT) || (state == CHECK) || (state == COMMIT);

   always_ff @(posedge clk) begin
      if (reset)
         state <= INIT;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ram_we    = 1'b0;
      ram_addr  = head_ptr;
      ram_wx    = head_x;
      ram_wy    = head_y;
      chk_issue = 1'b0;
      case (state)
         INIT: begin
            ram_we   = 1'b1;
            ram_addr = head_ptr - init_cnt;
            ram_wx   = head_x - XW'(init_cnt);
            if (init_cnt == '0)
               state_nxt = IDLE;
         end
         IDLE: begin
            if (tick)
               state_nxt = step_oob ? DEAD : CHECK;
         end
         CHECK: begin
            chk_issue = (chk_i <= chk_last);
            ram_addr  = head_ptr - AW'(chk_i);
            if (chk_hit)
               state_nxt = DEAD;
            else if (!chk_issue)
               state_nxt = COMMIT;
         end
         COMMIT: begin
            ram_we    = 1'b1;
            ram_addr  = head_ptr + A_ONE;
            ram_wx    = new_x;
            ram_wy    = new_y;
            state_nxt = IDLE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_x    <= XW'(GRID_W / 2);
         head_y    <= YW'(GRID_H / 2);
         length    <= LW'(INIT_LEN);
         cur_dir   <= DIR_RIGHT;
         head_ptr  <= AW'(INIT_LEN - 1);
         init_cnt  <= AW'(INIT_LEN - 1);
         grow_pend <= 1'b0;
         game_over <= 1'b0;
         moved     <= 1'b0;
         rd_valid  <= 1'b0;
         chk_i     <= L_ONE;
         cmp_vld   <= 1'b0;
         new_x     <= '0;
         new_y     <= '0;
      end else begin
         moved    <= 1'b0;
         rd_valid <= ({1'b0, rd_idx} < length);
         case (state)
            INIT: begin
               if (init_cnt != '0)
                  init_cnt <= init_cnt - A_ONE;
            end
            IDLE: begin
               if (tick) begin
                  cur_dir <= eff_dir;
                  new_x   <= step_x;
                  new_y   <= step_y;
                  chk_i   <= L_ONE;
                  cmp_vld <= 1'b0;
               end
            end
            CHECK: begin
               cmp_vld <= chk_issue;
               if (chk_issue)
                  chk_i <= chk_i + L_ONE;
            end
            COMMIT: begin
               head_ptr <= head_ptr + A_ONE;
               head_x   <= new_x;
               head_y   <= new_y;
               moved    <= 1'b1;
               if ((grow_pend || grow) && (length < L_MAX))
                  length <= length + L_ONE;
            end
            default: ;
         endcase
         if (state == COMMIT)
            grow_pend <= 1'b0;
         else if (grow && (state != DEAD))
            grow_pend <= 1'b1;
         if (state_nxt == DEAD)
            game_over <= 1'b1;
      end
   end

   cobra_seg_ram #(
      .DEPTH (MAX_LEN),
      .XW    (XW),
      .YW    (YW)
   ) u_seg_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wx    (ram_wx),
      .wy    (ram_wy),
      .ax    (ram_ax),
      .ay    (ram_ay),
      .raddr (head_ptr - rd_idx),
      .rx    (rd_x),
      .ry    (rd_y)
   );

endmodule
